// File: rtl/filter_ctrl_multi_if.sv
// Decoded command bus for the multi-channel filtration controller.
// The master side issues one-cycle duty strobes; the controller is the slave.
interface filter_ctrl_multi_if #(
    parameter int unsigned PWM_W = 8
);
    logic             i_cmd_valid;
    logic [2:0]       i_cmd_chan;
    logic [PWM_W-1:0] i_cmd_duty;

    modport master (
        output i_cmd_valid,
        output i_cmd_chan,
        output i_cmd_duty
    );

    modport slave (
        input i_cmd_valid,
        input i_cmd_chan,
        input i_cmd_duty
    );
endinterface

// File: rtl/filter_ctrl_multi.sv
// N-channel tank filtration controller: debounced floats, per-channel fill/return/drain FSM
// with fault detection, slew-limited pump duty and shared-counter PWM outputs.
module filter_ctrl_multi #(
    parameter int unsigned N_CH           = 2,
    parameter int unsigned PWM_W          = 8,
    parameter int unsigned DEB_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned RAMP_DIV       = 1024
) (
    input  logic                  clk_fpga,
    input  logic                  reset,
    filter_ctrl_multi_if.slave    cmd,
    input  logic [N_CH-1:0]       i_boia_cheia,
    input  logic [N_CH-1:0]       i_boia_vazia,
    output logic [N_CH-1:0]       o_motor,
    output logic [N_CH-1:0]       o_pwm_bomba_a,
    output logic [N_CH-1:0]       o_pwm_bomba_b,
    output logic [3*N_CH-1:0]     o_state,
    output logic [N_CH-1:0]       o_fault
);

    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned NB    = 2 * N_CH;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);

    typedef enum logic [2:0] {
        StStop      = 3'd0,
        StFilling   = 3'd1,
        StReturning = 3'd2,
        StDraining  = 3'd3,
        StFault     = 3'd4
    } state_t;

    function automatic logic [PWM_W-1:0] f_step(input logic [PWM_W-1:0] cur,
                                                input logic [PWM_W-1:0] tgt);
        if (cur < tgt) begin
            return cur + 1'b1;
        end else if (cur > tgt) begin
            return cur - 1'b1;
        end
        return cur;
    endfunction

    function automatic logic f_pwm(input logic [PWM_W-1:0] cnt, input logic [PWM_W-1:0] cur);
        return (cur == '1) || (cnt < cur);
    endfunction

    // Float bits packed as {vazia, cheia}: bit c = full, bit N_CH+c = empty.
    logic [NB-1:0]    w_raw;
    logic [NB-1:0]    r_meta;
    logic [NB-1:0]    r_sync;
    logic [NB-1:0]    r_deb;
    logic [DEB_W-1:0] r_deb_cnt [NB];

    assign w_raw = {i_boia_vazia, i_boia_cheia};

    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
            r_deb  <= '0;
            for (int b = 0; b < int'(NB); b++) begin
                r_deb_cnt[b] <= '0;
            end
        end else begin
            r_meta <= w_raw;
            r_sync <= r_meta;
            for (int b = 0; b < int'(NB); b++) begin
                if (r_sync[b] == r_deb[b]) begin
                    r_deb_cnt[b] <= '0;
                end else if (r_deb_cnt[b] == DEB_LAST) begin
                    r_deb[b]     <= r_sync[b];
                    r_deb_cnt[b] <= '0;
                end else begin
                    r_deb_cnt[b] <= r_deb_cnt[b] + 1'b1;
                end
            end
        end
    end

    // Commands pass through one register stage before reaching the channel FSMs.
    logic             r_cmd_valid;
    logic [2:0]       r_cmd_chan;
    logic [PWM_W-1:0] r_cmd_duty;
    logic [PRE_W-1:0] r_pre;
    logic [PWM_W-1:0] r_pwm_cnt;
    logic             w_tick;
    logic             w_nz;

    assign w_tick = (r_pre == PRE_LAST);
    assign w_nz   = (r_cmd_duty != '0);

    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            r_cmd_valid <= 1'b0;
            r_cmd_chan  <= '0;
            r_cmd_duty  <= '0;
            r_pre       <= '0;
            r_pwm_cnt   <= '0;
        end else begin
            r_cmd_valid <= cmd.i_cmd_valid;
            r_cmd_chan  <= cmd.i_cmd_chan;
            r_cmd_duty  <= cmd.i_cmd_duty;
            r_pre       <= w_tick ? '0 : r_pre + 1'b1;
            r_pwm_cnt   <= r_pwm_cnt + 1'b1;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_t           r_state;
        logic [PWM_W-1:0] r_duty;
        logic [PWM_W-1:0] r_cur_a;
        logic [PWM_W-1:0] r_cur_b;
        logic [TO_W-1:0]  r_tcnt;
        logic             r_motor;
        logic             r_fault;
        logic             r_pwm_a;
        logic             r_pwm_b;

        logic             w_hit;
        logic             w_full;
        logic             w_empty;
        logic             w_pump;
        logic             w_fault_in;
        logic [PWM_W-1:0] w_tgt_a;
        logic [PWM_W-1:0] w_tgt_b;

        assign w_hit      = r_cmd_valid && (r_cmd_chan == 3'(c));
        assign w_full     = r_deb[c];
        assign w_empty    = r_deb[N_CH + c];
        assign w_pump     = (r_state == StFilling) || (r_state == StReturning) ||
                            (r_state == StDraining);
        assign w_fault_in = (r_state != StFault) &&
                            ((w_full && w_empty) || (w_pump && (r_tcnt == TO_LAST)));
        assign w_tgt_a    = (r_state == StFilling) ? r_duty : '0;
        assign w_tgt_b    = ((r_state == StReturning) || (r_state == StDraining)) ? r_duty : '0;

        always_ff @(posedge clk_fpga) begin
            if (reset) begin
                r_state <= StStop;
                r_duty  <= '0;
                r_cur_a <= '0;
                r_cur_b <= '0;
                r_tcnt  <= '0;
                r_motor <= 1'b0;
                r_fault <= 1'b0;
                r_pwm_a <= 1'b0;
                r_pwm_b <= 1'b0;
            end else begin
                if (w_tick) begin
                    r_cur_a <= f_step(r_cur_a, w_tgt_a);
                    r_cur_b <= f_step(r_cur_b, w_tgt_b);
                end
                r_pwm_a <= f_pwm(r_pwm_cnt, r_cur_a);
                r_pwm_b <= f_pwm(r_pwm_cnt, r_cur_b);
                r_tcnt  <= w_pump ? r_tcnt + 1'b1 : '0;
                if (w_hit && w_nz && (r_state != StFault)) begin
                    r_duty <= r_cmd_duty;
                end

                // Fault entry kills pump drive on the same edge the state changes.
                if (w_fault_in) begin
                    r_state <= StFault;
                    r_tcnt  <= '0;
                    r_motor <= 1'b0;
                    r_fault <= 1'b1;
                    r_cur_a <= '0;
                    r_cur_b <= '0;
                    r_pwm_a <= 1'b0;
                    r_pwm_b <= 1'b0;
                end else begin
                    unique case (r_state)
                        StStop: begin
                            if (w_hit && w_nz) begin
                                r_state <= StFilling;
                                r_tcnt  <= '0;
                                r_motor <= 1'b1;
                            end
                        end
                        StFilling: begin
                            if (w_hit && !w_nz) begin
                                r_state <= StDraining;
                                r_tcnt  <= '0;
                            end else if (w_full) begin
                                r_state <= StReturning;
                                r_tcnt  <= '0;
                            end
                        end
                        StReturning: begin
                            if (w_hit && !w_nz) begin
                                r_state <= StDraining;
                                r_tcnt  <= '0;
                            end else if (w_empty) begin
                                r_state <= StFilling;
                                r_tcnt  <= '0;
                            end
                        end
                        StDraining: begin
                            if (w_hit && w_nz) begin
                                r_state <= StFilling;
                                r_tcnt  <= '0;
                            end else if (w_empty) begin
                                r_state <= StStop;
                                r_tcnt  <= '0;
                                r_motor <= 1'b0;
                            end
                        end
                        StFault: begin
                            r_cur_a <= '0;
                            r_cur_b <= '0;
                            r_pwm_a <= 1'b0;
                            r_pwm_b <= 1'b0;
                            if (w_hit && !w_nz) begin
                                r_state <= StStop;
                                r_tcnt  <= '0;
                                r_fault <= 1'b0;
                            end
                        end
                        default: r_state <= StStop;
                    endcase
                end
            end
        end

        assign o_state[3*c +: 3] = r_state;
        assign o_motor[c]        = r_motor;
        assign o_fault[c]        = r_fault;
        assign o_pwm_bomba_a[c]  = r_pwm_a;
        assign o_pwm_bomba_b[c]  = r_pwm_b;
    end

endmodule
